mem_access_ctrl: RTL and testbench

- Load/store sequencer directly upstream of the byte-addressed data cache.
- Accepts one CPU memory request at a time over a valid/ready handshake and drives the cache-side signals: rw_ctrl, size_ctrl, address and the shared 32-bit tristate data bus.
- Sequences the single-cycle write strobe, captures read data after a programmable wait, sign/zero-extends loads and returns a one-cycle response pulse.

---
 rtl/mem_access_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store sequencer directly upstream of the byte-addressed data cache.
// Accepts one request at a time, drives rw/size/address and the shared tristate data bus,
// captures load data after WAIT_CYCLES extra cycles and returns a one-cycle response.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned half/word requests fault with no cache activity.
module mem_access_ctrl #(
   parameter int unsigned WAIT_CYCLES = 0,
   parameter int unsigned CNT_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [1:0]       req_size,
   input  logic             req_signed,
   input  logic [15:0]      req_addr,
   input  logic [31:0]      req_wdata,
   output logic             rsp_valid,
   output logic [31:0]      rsp_rdata,
   output logic             rsp_fault,
   output logic             mem_rw_ctrl,
   output logic [1:0]       mem_size_ctrl,
   output logic [15:0]      mem_address,
   inout  wire logic [31:0] mem_data_bus
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES);

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             lat_we;
   logic             lat_signed;
   logic [1:0]       lat_size;
   logic [31:0]      lat_wdata;
   logic             bad_req;

   // Requests rejected without touching the cache: illegal size, plus misalignment when checked.
   always_comb begin
      bad_req = (req_size == 2'd0);
`ifdef MEM_ALIGN_CHECK_EN
      if ((req_size == 2'd2) && req_addr[0]) begin
         bad_req = 1'b1;
      end
      if ((req_size == 2'd3) && (req_addr[1:0] != 2'b00)) begin
         bad_req = 1'b1;
      end
`endif
   end

   // Right-justified load data: keep the valid low bits, fill the rest with sign or zero.
   function automatic logic [31:0] extend_load(input logic [31:0] data,
                                               input logic [1:0]  size,
                                               input logic        sgn);
      logic [31:0] res;
      case (size)
         2'd1:    res = {{24{sgn & data[7]}}, data[7:0]};
         2'd2:    res = {{16{sgn & data[15]}}, data[15:0]};
         default: res = data;
      endcase
      return res;
   endfunction

   // The controller owns the bus only during its registered write strobe; the cache drives it otherwise.
   assign mem_data_bus = mem_rw_ctrl ? lat_wdata : 'z;

   // Sequencer FSM: handshake, access timing and response, all outputs registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         lat_we        <= 1'b0;
         lat_signed    <= 1'b0;
         lat_size      <= '0;
         lat_wdata     <= '0;
         req_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_fault     <= 1'b0;
         mem_rw_ctrl   <= 1'b0;
         mem_size_ctrl <= '0;
         mem_address   <= '0;
      end else begin
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               // Gated by the registered ready so the cycle right after reset accepts nothing.
               if (req_ready && req_valid) begin
                  req_ready  <= 1'b0;
                  lat_we     <= req_we;
                  lat_signed <= req_signed;
                  lat_size   <= req_size;
                  lat_wdata  <= req_wdata;
                  if (bad_req) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_fault <= 1'b1;
                     rsp_rdata <= '0;
                  end else begin
                     state         <= ACCESS;
                     wait_cnt      <= '0;
                     mem_address   <= req_addr;
                     mem_size_ctrl <= req_size;
                     // With no wait cycles the single ACCESS cycle is also the strobe cycle.
                     mem_rw_ctrl   <= req_we && (LAST_CNT == '0);
                  end
               end
            end
            ACCESS: begin
               if (wait_cnt == LAST_CNT) begin
                  state         <= RESP;
                  rsp_valid     <= 1'b1;
                  rsp_fault     <= 1'b0;
                  rsp_rdata     <= lat_we ? '0 : extend_load(mem_data_bus, lat_size, lat_signed);
                  mem_rw_ctrl   <= 1'b0;
                  mem_size_ctrl <= '0;
               end else begin
                  wait_cnt    <= wait_cnt + CNT_W'(1);
                  // Raise the strobe one edge early so it is high in the final ACCESS cycle only.
                  mem_rw_ctrl <= lat_we && ((wait_cnt + CNT_W'(1)) == LAST_CNT);
               end
            end
            RESP: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               rsp_fault <= 1'b0;
               rsp_rdata <= '0;
               req_ready <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: two controllers (WAIT_CYCLES 0 and 3), each with a big-endian cache model
// on its tristate bus, checked against a transaction-level memory image kept in the bench.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rv [2];
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;

   logic        ready   [2];
   logic        rspv    [2];
   logic [31:0] rdata   [2];
   logic        fault_o [2];
   logic        rw      [2];
   logic [1:0]  msz     [2];
   logic [15:0] maddr   [2];

   wire  [31:0] bus0;
   wire  [31:0] bus1;
   logic [31:0] bus_obs  [2];
   logic [31:0] cache_rd [2];
   logic [31:0] junk;
   logic        cache_clear;

   logic [7:0]  cmem [2][65536];
   logic [7:0]  rmem [2][65536];

   int tests = 0;
   int fails = 0;

`ifdef MEM_ALIGN_CHECK_EN
   localparam bit ALIGN_CHECK = 1'b1;
`else
   localparam bit ALIGN_CHECK = 1'b0;
`endif

   always #5 clk = ~clk;

   mem_access_ctrl #(.WAIT_CYCLES(0), .CNT_W(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(ready[0]),
      .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rspv[0]), .rsp_rdata(rdata[0]), .rsp_fault(fault_o[0]),
      .mem_rw_ctrl(rw[0]), .mem_size_ctrl(msz[0]), .mem_address(maddr[0]),
      .mem_data_bus(bus0)
   );

   mem_access_ctrl #(.WAIT_CYCLES(3), .CNT_W(4)) dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(ready[1]),
      .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rspv[1]), .rsp_rdata(rdata[1]), .rsp_fault(fault_o[1]),
      .mem_rw_ctrl(rw[1]), .mem_size_ctrl(msz[1]), .mem_address(maddr[1]),
      .mem_data_bus(bus1)
   );

   assign bus0 = rw[0] ? 32'bz : cache_rd[0];
   assign bus1 = rw[1] ? 32'bz : cache_rd[1];
   assign bus_obs[0] = bus0;
   assign bus_obs[1] = bus1;

   // Cache read side: right-justified big-endian data, upper unused bits carry junk.
   always_comb begin
      for (int d = 0; d < 2; d++) begin
         cache_rd[d] = junk;
         case (msz[d])
            2'd1: cache_rd[d][7:0]  = cmem[d][maddr[d]];
            2'd2: cache_rd[d][15:0] = {cmem[d][maddr[d]], cmem[d][maddr[d] + 16'd1]};
            2'd3: cache_rd[d]       = {cmem[d][maddr[d]], cmem[d][maddr[d] + 16'd1],
                                       cmem[d][maddr[d] + 16'd2], cmem[d][maddr[d] + 16'd3]};
            default: ;
         endcase
      end
   end

   // Cache write side: writes at every edge where rw_ctrl is high, address wraps mod 2^16.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (cache_clear) begin
            for (int i = 0; i < 65536; i++) cmem[d][i] <= 8'(i * 7 + d * 3);
         end else if (rw[d] === 1'b1) begin
            case (msz[d])
               2'd1: cmem[d][maddr[d]] <= bus_obs[d][7:0];
               2'd2: begin
                  cmem[d][maddr[d]]         <= bus_obs[d][15:8];
                  cmem[d][maddr[d] + 16'd1] <= bus_obs[d][7:0];
               end
               2'd3: begin
                  cmem[d][maddr[d]]         <= bus_obs[d][31:24];
                  cmem[d][maddr[d] + 16'd1] <= bus_obs[d][23:16];
                  cmem[d][maddr[d] + 16'd2] <= bus_obs[d][15:8];
                  cmem[d][maddr[d] + 16'd3] <= bus_obs[d][7:0];
               end
               default: ;
            endcase
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [1:0] s);
      return (s == 2'd1) ? 1 : (s == 2'd2) ? 2 : 4;
   endfunction

   function automatic bit ref_fault(input logic [1:0] s, input logic [15:0] a);
      bit mis;
      mis = (s == 2'd2 && (a % 2) != 0) || (s == 2'd3 && (a % 4) != 0);
      return (s == 2'd0) || (ALIGN_CHECK && mis);
   endfunction

   function automatic logic [31:0] ref_load(input int d, input logic [1:0] s, input logic sgn,
                                            input logic [15:0] a);
      int     n = nbytes(s);
      longint v = 0;
      for (int i = 0; i < n; i++) v = v * 256 + longint'(rmem[d][16'(a + 16'(i))]);
      if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      return 32'(v);
   endfunction

   task automatic ref_store(input int d, input logic [1:0] s, input logic [15:0] a,
                            input logic [31:0] wd);
      int n = nbytes(s);
      for (int i = 0; i < n; i++)
         rmem[d][16'(a + 16'(i))] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
   endtask

   // One full transaction on controller d; hold keeps a garbage request asserted while busy.
   task automatic run_txn(input int d, input logic we, input logic [1:0] s, input logic sgn,
                          input logic [15:0] a, input logic [31:0] wd, input bit hold,
                          input string tag);
      int          w        = (d == 1) ? 3 : 0;
      bit          f        = ref_fault(s, a);
      int          last     = f ? 2 : w + 3;
      int          exp_rsp  = f ? 1 : w + 2;
      int          exp_strb = (we && !f) ? 1 : 0;
      int          guard    = 0;
      int          rsp_at   = -1;
      int          rsp_n    = 0;
      int          strb_n   = 0;
      int          strb_at  = -1;
      bit          ready_bad = 1'b0;
      bit          addr_bad  = 1'b0;
      bit          bus_bad   = 1'b0;
      logic [31:0] got_rdata = '0;
      logic        got_fault = 1'b0;
      logic [31:0] exp_rdata;

      exp_rdata = (we || f) ? 32'h0 : ref_load(d, s, sgn, a);
      junk = $urandom;
      while (ready[d] !== 1'b1 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      tests++;
      if (ready[d] !== 1'b1) begin
         fails++;
         $display("FAIL %s ready_wait: req_ready=%b required 1 within 40 cycles", tag, ready[d]);
         return;
      end
      req_we = we; req_size = s; req_signed = sgn; req_addr = a; req_wdata = wd;
      rv[d] = 1'b1;
      @(posedge clk);
      #1;
      if (hold) begin
         req_addr  = ~a;
         req_we    = ~we;
         req_size  = (s == 2'd3) ? 2'd1 : s + 2'd1;
         req_wdata = ~wd;
      end else begin
         rv[d] = 1'b0;
      end
      for (int k = 1; k <= last; k++) begin
         @(negedge clk);
         if (rspv[d] === 1'b1) begin
            rsp_n++;
            if (rsp_at < 0) rsp_at = k;
            got_rdata = rdata[d];
            got_fault = fault_o[d];
         end
         if (rw[d] === 1'b1) begin
            strb_n++;
            strb_at = k;
            if (bus_obs[d] !== wd) bus_bad = 1'b1;
         end else if (bus_obs[d] !== cache_rd[d]) begin
            bus_bad = 1'b1;
         end
         if (ready[d] !== ((k == last) ? 1'b1 : 1'b0)) ready_bad = 1'b1;
         if (!f && k <= w + 1 && (maddr[d] !== a || msz[d] !== s)) addr_bad = 1'b1;
         if ((f || k >= w + 2) && msz[d] !== 2'd0) addr_bad = 1'b1;
         if (hold && k == last) rv[d] = 1'b0;
      end
      tests++;
      if (rsp_at !== exp_rsp || rsp_n !== 1) begin
         fails++;
         $display("FAIL %s rsp_timing: rsp_valid first at cycle %0d (%0d pulses), required cycle %0d (1 pulse)",
                  tag, rsp_at, rsp_n, exp_rsp);
      end
      tests++;
      if (got_fault !== f) begin
         fails++;
         $display("FAIL %s rsp_fault: got %b required %b", tag, got_fault, f);
      end
      tests++;
      if (got_rdata !== exp_rdata) begin
         fails++;
         $display("FAIL %s rsp_rdata: got %h required %h", tag, got_rdata, exp_rdata);
      end
      tests++;
      if (strb_n !== exp_strb || (exp_strb == 1 && strb_at !== w + 1)) begin
         fails++;
         $display("FAIL %s write_strobe: %0d strobes at cycle %0d, required %0d at cycle %0d",
                  tag, strb_n, strb_at, exp_strb, w + 1);
      end
      tests++;
      if (ready_bad !== 1'b0) begin
         fails++;
         $display("FAIL %s req_ready: wrong level in some cycle, required low until cycle %0d", tag, last);
      end
      tests++;
      if (addr_bad !== 1'b0) begin
         fails++;
         $display("FAIL %s mem_addr_size: address/size not %h/%0d during access or size not 0 after",
                  tag, a, s);
      end
      tests++;
      if (bus_bad !== 1'b0) begin
         fails++;
         $display("FAIL %s data_bus: bus not %h during strobe or driven by controller otherwise", tag, wd);
      end
      if (we && !f) ref_store(d, s, a, wd);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0; cache_clear = 1'b1;
      rv[0] = 1'b0; rv[1] = 1'b0;
      req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
      junk = 32'h5A5A_A5A5;
      repeat (3) @(negedge clk);
      cache_clear = 1'b0;
      for (int d = 0; d < 2; d++) begin
         tests++;
         if (ready[d] !== 1'b0 || rspv[d] !== 1'b0 || fault_o[d] !== 1'b0) begin
            fails++;
            $display("FAIL reset_hs[%0d]: ready/valid/fault=%b%b%b required 000", d, ready[d], rspv[d], fault_o[d]);
         end
         tests++;
         if (rdata[d] !== 32'h0) begin
            fails++;
            $display("FAIL reset_rdata[%0d]: got %h required 00000000", d, rdata[d]);
         end
         tests++;
         if (rw[d] !== 1'b0 || msz[d] !== 2'd0 || maddr[d] !== 16'h0) begin
            fails++;
            $display("FAIL reset_mem[%0d]: rw/size/addr=%b/%0d/%h required 0/0/0000", d, rw[d], msz[d], maddr[d]);
         end
         tests++;
         if (bus_obs[d] !== cache_rd[d]) begin
            fails++;
            $display("FAIL reset_bus[%0d]: bus %h required cache value %h", d, bus_obs[d], cache_rd[d]);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         tests++;
         if (ready[d] !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready[%0d]: got %b required 1", d, ready[d]);
         end
      end
   endtask

   task automatic test_store_load();
      run_txn(0, 1'b1, 2'd3, 1'b0, 16'h0010, 32'h1122_3344, 1'b0, "w0_store_word");
      run_txn(0, 1'b0, 2'd3, 1'b0, 16'h0010, 32'h0, 1'b0, "w0_load_word");
      tests++;
      if (rmem[0][16'h0010] !== 8'h11 || rmem[0][16'h0013] !== 8'h44) begin
         fails++;
         $display("FAIL model_bigendian: bytes %h..%h required 11..44", rmem[0][16'h0010], rmem[0][16'h0013]);
      end
   endtask

   task automatic test_wait3_back_to_back();
      run_txn(1, 1'b1, 2'd3, 1'b0, 16'h0010, 32'h1122_3344, 1'b1, "w3_store_word_hold");
      run_txn(1, 1'b0, 2'd3, 1'b0, 16'h0010, 32'h0, 1'b1, "w3_load_word_hold");
      run_txn(1, 1'b0, 2'd2, 1'b1, 16'h0012, 32'h0, 1'b0, "w3_load_half");
   endtask

   task automatic test_extend();
      run_txn(0, 1'b1, 2'd1, 1'b0, 16'h0020, 32'hABCD_EF85, 1'b0, "store_byte_85");
      run_txn(0, 1'b0, 2'd1, 1'b1, 16'h0020, 32'h0, 1'b0, "load_byte_signed");
      run_txn(0, 1'b0, 2'd1, 1'b0, 16'h0020, 32'h0, 1'b0, "load_byte_unsigned");
      run_txn(0, 1'b1, 2'd2, 1'b0, 16'h0022, 32'h1234_8001, 1'b0, "store_half_8001");
      run_txn(0, 1'b0, 2'd2, 1'b1, 16'h0022, 32'h0, 1'b0, "load_half_signed");
      run_txn(0, 1'b0, 2'd2, 1'b0, 16'h0022, 32'h0, 1'b0, "load_half_unsigned");
      tests++;
      if (ref_load(0, 2'd1, 1'b1, 16'h0020) !== 32'hFFFF_FF85) begin
         fails++;
         $display("FAIL model_sext_byte: got %h required FFFFFF85", ref_load(0, 2'd1, 1'b1, 16'h0020));
      end
   endtask

   task automatic test_fault();
      run_txn(0, 1'b1, 2'd0, 1'b0, 16'h0010, 32'hFFFF_FFFF, 1'b0, "w0_size0_store");
      run_txn(1, 1'b0, 2'd0, 1'b1, 16'h0020, 32'h0, 1'b0, "w3_size0_load");
      run_txn(0, 1'b0, 2'd3, 1'b0, 16'h0010, 32'h0, 1'b0, "w0_load_after_fault");
   endtask

   task automatic test_align_wrap();
      run_txn(0, 1'b1, 2'd3, 1'b0, 16'h0010, 32'hCAFE_F00D, 1'b0, "store_word_aligned");
      run_txn(0, 1'b1, 2'd3, 1'b0, 16'h0012, 32'hDEAD_BEEF, 1'b0, "store_word_misaligned");
      run_txn(0, 1'b0, 2'd3, 1'b0, 16'h0010, 32'h0, 1'b0, "load_word_prior");
      run_txn(0, 1'b0, 2'd1, 1'b0, 16'h0015, 32'h0, 1'b0, "load_byte_0015");
      run_txn(1, 1'b0, 2'd2, 1'b1, 16'h0013, 32'h0, 1'b0, "load_half_misaligned");
      run_txn(0, 1'b1, 2'd3, 1'b0, 16'hFFFE, 32'hA1B2_C3D4, 1'b0, "store_word_wrap");
      run_txn(0, 1'b0, 2'd1, 1'b0, 16'h0001, 32'h0, 1'b0, "load_byte_wrapped");
      run_txn(0, 1'b0, 2'd2, 1'b0, 16'hFFFE, 32'h0, 1'b0, "load_half_top");
   endtask

   task automatic test_reset_mid_access();
      bit seen = 1'b0;
      junk = $urandom;
      req_we = 1'b0; req_size = 2'd3; req_signed = 1'b0; req_addr = 16'h0010; req_wdata = '0;
      rv[1] = 1'b1;
      @(posedge clk);
      #1 rv[1] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      tests++;
      if (rspv[1] !== 1'b0 || ready[1] !== 1'b0 || rdata[1] !== 32'h0 || fault_o[1] !== 1'b0) begin
         fails++;
         $display("FAIL midreset_rsp: valid/ready/fault=%b%b%b rdata=%h required 000 00000000",
                  rspv[1], ready[1], fault_o[1], rdata[1]);
      end
      tests++;
      if (rw[1] !== 1'b0 || msz[1] !== 2'd0 || maddr[1] !== 16'h0) begin
         fails++;
         $display("FAIL midreset_mem: rw/size/addr=%b/%0d/%h required 0/0/0000", rw[1], msz[1], maddr[1]);
      end
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (rspv[1] === 1'b1) seen = 1'b1;
      end
      tests++;
      if (seen !== 1'b0) begin
         fails++;
         $display("FAIL midreset_no_rsp: rsp_valid seen=%b required 0", seen);
      end
      run_txn(1, 1'b0, 2'd3, 1'b0, 16'h0010, 32'h0, 1'b0, "post_reset_load");
   endtask

   task automatic test_random();
      for (int i = 0; i < 80; i++) begin
         int          d   = int'($urandom_range(0, 1));
         logic        we  = 1'($urandom_range(0, 1));
         logic [1:0]  s   = 2'($urandom_range(0, 3));
         logic        sgn = 1'($urandom_range(0, 1));
         logic [15:0] a;
         logic [31:0] wd  = $urandom;
         bit          h   = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 9) == 0) a = 16'hFFFC + 16'($urandom_range(0, 3));
         else a = 16'($urandom_range(0, 63));
         run_txn(d, we, s, sgn, a, wd, h, "random");
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "timeout");
   end

   initial begin
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 65536; i++) rmem[d][i] = 8'(i * 7 + d * 3);
      test_reset();
      test_store_load();
      test_wait3_back_to_back();
      test_extend();
      test_fault();
      test_align_wrap();
      test_reset_mid_access();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
